// File: rtl/tia_fb_scanout.sv
// Frame store for the TIA pixel stream, replayed as a 640x480@60 raster with 2x2 pixel doubling.
// Latency: colour/sync/de appear 2 pix_ce ticks after the counters; frame_start_o is combinational.
// Backpressure: none; writes are never stalled and scanout only advances on pix_ce_i.
module tia_fb_scanout #(
    parameter int H_RES      = 320,
    parameter int V_RES      = 240,
    parameter int Y_OFFSET   = 16,
    parameter int DATA_WIDTH = 16
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  pix_ce_i,
    input  logic                  wr_i,
    input  logic [16:0]           wr_addr_i,
    input  logic [DATA_WIDTH-1:0] wr_data_i,
    output logic [7:0]            red_o,
    output logic [7:0]            green_o,
    output logic [7:0]            blue_o,
    output logic                  hsync_o,
    output logic                  vsync_o,
    output logic                  de_o,
    output logic                  frame_start_o
);

    localparam int FB_DEPTH = H_RES * V_RES;
    localparam int AW       = $clog2(FB_DEPTH);

    localparam logic [16:0]   WR_LO    = 17'(Y_OFFSET * H_RES);
    localparam logic [16:0]   WR_HI    = 17'((Y_OFFSET + V_RES) * H_RES);
    localparam logic [AW-1:0] ROW_STEP = AW'(H_RES);

    localparam logic [9:0] H_ACT    = 10'd640;
    localparam logic [9:0] H_SYNC_S = 10'd656;
    localparam logic [9:0] H_SYNC_E = 10'd752;
    localparam logic [9:0] H_LAST   = 10'd799;
    localparam logic [9:0] V_ACT    = 10'd480;
    localparam logic [9:0] V_SYNC_S = 10'd490;
    localparam logic [9:0] V_SYNC_E = 10'd492;
    localparam logic [9:0] V_LAST   = 10'd524;

    logic [DATA_WIDTH-1:0] mem [FB_DEPTH];

    logic [9:0]            h_q, h_d, v_q, v_d;
    logic [AW-1:0]         row_base_q, row_base_d;
    logic                  act_s0, hs_s0, vs_s0;
    logic [AW-1:0]         rd_addr;
    logic                  wr_en;
    logic [AW-1:0]         wr_idx;
    logic                  act_s1_q, hs_s1_q, vs_s1_q;
    logic [DATA_WIDTH-1:0] rd_dat_q;
    logic [7:0]            red_q, green_q, blue_q, red_d, green_d, blue_d;
    logic                  hs_q, vs_q, de_q;

    assign wr_en  = wr_i && (wr_addr_i >= WR_LO) && (wr_addr_i < WR_HI);
    assign wr_idx = AW'(wr_addr_i - WR_LO);

    always_comb begin
        h_d        = h_q;
        v_d        = v_q;
        row_base_d = row_base_q;
        if (pix_ce_i) begin
            if (h_q == H_LAST) begin
                h_d = '0;
                if (v_q == V_LAST) begin
                    v_d        = '0;
                    row_base_d = '0;
                end else begin
                    v_d = v_q + 10'd1;
                    // Each framebuffer row is shown on two lines; step after the second.
                    if ((v_q < V_ACT) && v_q[0]) begin
                        row_base_d = row_base_q + ROW_STEP;
                    end
                end
            end else begin
                h_d = h_q + 10'd1;
            end
        end
    end

    assign act_s0  = (h_q < H_ACT) && (v_q < V_ACT);
    assign hs_s0   = !((h_q >= H_SYNC_S) && (h_q < H_SYNC_E));
    assign vs_s0   = !((v_q >= V_SYNC_S) && (v_q < V_SYNC_E));
    assign rd_addr = row_base_q + AW'(h_q[9:1]);

    assign frame_start_o = pix_ce_i && (h_q == H_LAST) && (v_q == V_LAST);

    // Non-blocking read and write on the same edge give read-before-write on a collision.
    always_ff @(posedge clk_i) begin
        if (wr_en) begin
            mem[wr_idx] <= wr_data_i;
        end
        if (pix_ce_i && act_s0) begin
            rd_dat_q <= mem[rd_addr];
        end
    end

    always_comb begin
        red_d   = '0;
        green_d = '0;
        blue_d  = '0;
        if (act_s1_q) begin
            red_d   = {rd_dat_q[15:11], rd_dat_q[15:13]};
            green_d = {rd_dat_q[10:5],  rd_dat_q[10:9]};
            blue_d  = {rd_dat_q[4:0],   rd_dat_q[4:2]};
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            h_q        <= '0;
            v_q        <= '0;
            row_base_q <= '0;
            act_s1_q   <= 1'b0;
            hs_s1_q    <= 1'b1;
            vs_s1_q    <= 1'b1;
            red_q      <= '0;
            green_q    <= '0;
            blue_q     <= '0;
            hs_q       <= 1'b1;
            vs_q       <= 1'b1;
            de_q       <= 1'b0;
        end else begin
            h_q        <= h_d;
            v_q        <= v_d;
            row_base_q <= row_base_d;
            if (pix_ce_i) begin
                act_s1_q <= act_s0;
                hs_s1_q  <= hs_s0;
                vs_s1_q  <= vs_s0;
                red_q    <= red_d;
                green_q  <= green_d;
                blue_q   <= blue_d;
                hs_q     <= hs_s1_q;
                vs_q     <= vs_s1_q;
                de_q     <= act_s1_q;
            end
        end
    end

    assign red_o   = red_q;
    assign green_o = green_q;
    assign blue_o  = blue_q;
    assign hsync_o = hs_q;
    assign vsync_o = vs_q;
    assign de_o    = de_q;

endmodule

// File: tb/tb_tia_fb_scanout.sv
// Bench for tia_fb_scanout: random pixel writes and scanout checked against a tick-indexed raster model.
module tb_tia_fb_scanout;

    localparam int H_RES     = 320;
    localparam int V_RES     = 240;
    localparam int Y_OFF     = 16;
    localparam int FB_LO     = Y_OFF * H_RES;
    localparam int FB_HI     = (Y_OFF + V_RES) * H_RES;
    localparam int FILL_ROWS = 20;
    localparam logic [26:0] RST_TUPLE = {24'h0, 1'b1, 1'b1, 1'b0};

    logic        clk_i     = 1'b0;
    logic        rst_ni    = 1'b0;
    logic        pix_ce_i  = 1'b0;
    logic        wr_i      = 1'b0;
    logic [16:0] wr_addr_i = '0;
    logic [15:0] wr_data_i = '0;
    logic [7:0]  red_o, green_o, blue_o;
    logic        hsync_o, vsync_o, de_o, frame_start_o;

    tia_fb_scanout dut (
        .clk_i         (clk_i),
        .rst_ni        (rst_ni),
        .pix_ce_i      (pix_ce_i),
        .wr_i          (wr_i),
        .wr_addr_i     (wr_addr_i),
        .wr_data_i     (wr_data_i),
        .red_o         (red_o),
        .green_o       (green_o),
        .blue_o        (blue_o),
        .hsync_o       (hsync_o),
        .vsync_o       (vsync_o),
        .de_o          (de_o),
        .frame_start_o (frame_start_o)
    );

    always #5 clk_i = ~clk_i;

    logic [15:0] model [H_RES*V_RES];
    int          n_checks = 0;
    int          n_err    = 0;
    int          T;
    logic [26:0] pend, out_exp;
    logic        hs_prev, de_prev;
    int          hs_low, de_run, last_fall;

    // Expected {rgb, hsync, vsync, de} for raster tick index s, from the frame store model.
    function automatic logic [26:0] ref_px(input int s);
        int          h, v;
        logic        act, hs, vs;
        logic [15:0] p;
        logic [23:0] rgb;
        h   = s % 800;
        v   = (s / 800) % 525;
        act = (h < 640) && (v < 480);
        hs  = !((h >= 656) && (h < 752));
        vs  = !((v >= 490) && (v < 492));
        rgb = '0;
        if (act) begin
            p   = model[(v / 2) * H_RES + h / 2];
            rgb = {p[15:11], p[15:13], p[10:5], p[10:9], p[4:0], p[4:2]};
        end
        return {rgb, hs, vs, act};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        T         = 0;
        pend      = RST_TUPLE;
        out_exp   = RST_TUPLE;
        hs_prev   = 1'b1;
        de_prev   = 1'b0;
        hs_low    = 0;
        de_run    = 0;
        last_fall = -1;
    endtask

    task automatic rand_wr(output logic w, output logic [16:0] a, output logic [15:0] d);
        w = 1'($urandom_range(0, 1));
        d = 16'($urandom);
        if ($urandom_range(0, 4) == 0) begin
            if ($urandom_range(0, 1) == 1) a = 17'($urandom_range(0, FB_LO - 1));
            else                           a = 17'($urandom_range(FB_HI, 131071));
        end else begin
            a = 17'($urandom_range(FB_LO, FB_LO + FILL_ROWS * H_RES - 1));
            if (int'(a) == FB_LO || int'(a) == FB_LO + H_RES + 2) w = 1'b0;
        end
    endtask

    // Entered and left at posedge+1.
    task automatic cycle(input logic ce, input logic wr, input logic [16:0] addr, input logic [15:0] dat);
        int          os, sh, sv;
        logic [26:0] obs;
        pix_ce_i  = ce;
        wr_i      = wr;
        wr_addr_i = addr;
        wr_data_i = dat;
        #1;
        chk("frame_start", 32'(frame_start_o), 32'(ce && (T % 420000 == 419999)));
        @(posedge clk_i);
        if (ce) begin
            T++;
            out_exp = pend;
            pend    = ref_px(T - 1);
        end
        if (wr && int'(addr) >= FB_LO && int'(addr) < FB_HI) model[int'(addr) - FB_LO] = dat;
        #1;
        obs = {red_o, green_o, blue_o, hsync_o, vsync_o, de_o};
        chk("pixel", 32'(obs), 32'(out_exp));
        if (ce && T >= 2) begin
            os = T - 2;
            sh = os % 800;
            sv = (os / 800) % 525;
            if (sh < 2 && sv < 2)
                chk("red_block", 32'({red_o, green_o, blue_o}), 32'h00FF0000);
            if ((sh == 4 && sv == 2) || (sh == 5 && sv == 3))
                chk("blue_px", 32'({red_o, green_o, blue_o}), 32'h000000FF);
            if (!hsync_o && hs_prev) begin
                if (last_fall >= 0) chk("line_len", 32'(T - last_fall), 32'd800);
                last_fall = T;
                hs_low    = 0;
            end
            if (!hsync_o) hs_low++;
            if (hsync_o && !hs_prev && last_fall >= 0) chk("hs_width", 32'(hs_low), 32'd96);
            if (de_o) de_run++;
            if (!de_o && de_prev) begin
                chk("de_width", 32'(de_run), 32'd640);
                de_run = 0;
            end
            hs_prev = hsync_o;
            de_prev = de_o;
        end
    endtask

    initial begin
        logic        w;
        logic [16:0] a;
        logic [15:0] d;

        model_reset();
        rst_ni = 1'b0;
        repeat (3) @(posedge clk_i);
        #1;
        chk("reset_out", 32'({red_o, green_o, blue_o, hsync_o, vsync_o, de_o}), 32'(RST_TUPLE));
        chk("reset_fs", 32'(frame_start_o), 32'd0);
        rst_ni = 1'b1;

        // Fill the rows the bench will scan, scanout idle.
        for (int i = 0; i < FILL_ROWS * H_RES; i++)
            cycle(1'b0, 1'b1, 17'(FB_LO + i), 16'($urandom));
        cycle(1'b0, 1'b1, 17'(FB_LO), 16'hF800);
        cycle(1'b0, 1'b1, 17'(FB_LO + H_RES + 2), 16'h001F);
        cycle(1'b0, 1'b1, 17'(FB_LO - 1), 16'hFFFF);
        cycle(1'b0, 1'b1, 17'(FB_HI), 16'hFFFF);

        // Free run with background writes; one write collides with the read of (20,6).
        while (T < 39 * 800 + 302) begin
            rand_wr(w, a, d);
            if (T == 6 * 800 + 20) begin
                w = 1'b1;
                a = 17'(FB_LO + 3 * H_RES + 10);
                d = 16'h07E0;
            end
            cycle(1'b1, w, a, d);
        end

        // Asynchronous reset mid-line while de is high.
        #2;
        wr_i     = 1'b0;
        pix_ce_i = 1'b0;
        rst_ni   = 1'b0;
        #1;
        chk("async_rst_out", 32'({red_o, green_o, blue_o, hsync_o, vsync_o, de_o}), 32'(RST_TUPLE));
        chk("async_rst_fs", 32'(frame_start_o), 32'd0);
        model_reset();
        @(posedge clk_i);
        #1;
        rst_ni = 1'b1;

        // Restart with the pixel enable on every fourth clock.
        for (int c = 0; c < 20000 && T < 4 * 800 + 2; c++) begin
            rand_wr(w, a, d);
            cycle((c % 4) == 3, w, a, d);
        end
        chk("ce_quarter_ticks", 32'(T), 32'(4 * 800 + 2));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule

// File: doc/tia_fb_scanout.md
# tia_fb_scanout

Framebuffer and display scanout that consumes the TIA pixel-write stream (17-bit address, 16-bit RGB565 data, one-cycle write strobe) and replays it as a 640x480@60 raster with 2x2 pixel doubling. It owns the dual-port frame store. The write side is driven by the TIA at whatever rate it produces pixels, and the read side runs on a pixel clock-enable from the video output block. Both sides share the single system clock.

## Interface
Parameters:
- H_RES, 320: framebuffer width in pixels.
- V_RES, 240: framebuffer height in rows.
- Y_OFFSET, 16: TIA row number that maps to framebuffer row 0.
- DATA_WIDTH, 16: pixel width, RGB565.

Ports:
- clk_i  in  1  system clock; every register is on the rising edge.
- rst_ni  in  1  asynchronous, active-low reset.
- pix_ce_i  in  1  pixel clock-enable (25 MHz equivalent); all scanout logic advances only on this signal.
- wr_i  in  1  pixel write strobe (TIA vid_wr).
- wr_addr_i  in  17  TIA address, row*320+col (TIA vid_addr).
- wr_data_i  in  16  RGB565 pixel (TIA vid_out).
- red_o, green_o, blue_o  out  8 each  expanded colour; all zero outside the active area.
- hsync_o, vsync_o  out  1  sync outputs, active low.
- de_o  out  1  data enable, high in the 640x480 active area.
- frame_start_o  out  1  one-clock pulse on the pix_ce_i at which the counters wrap to (0,0).

## Operation
Write side:
- A write is accepted when wr_i=1 and Y_OFFSET*H_RES <= wr_addr_i < (Y_OFFSET+V_RES)*H_RES, i.e. 5120..81919 with default parameters.
- Accepted writes store wr_data_i at address wr_addr_i - Y_OFFSET*H_RES, in the same cycle.
- Writes outside that range are dropped silently.
- The write side is never stalled and is independent of pix_ce_i.

Timing generator:
- h counter 0..799: active 0..639, front porch 640..655, sync 656..751, back porch 752..799.
- v counter 0..524: active 0..479, front porch 480..489, sync 490..491, back porch 492..524.
- h increments on each pix_ce_i. At 799 it wraps to 0 and v increments. At v=524 with h=799, v wraps to 0.

Read address:
- fb_addr = (v>>1)*H_RES + (h>>1).
- Generated incrementally with no multiplier. A row-base register adds H_RES after each odd active line and clears at v wrap. The column term is h[9:1].
- No read is issued outside the active area.

Pipeline, with each stage advancing on pix_ce_i:
- S0: counters produce the address, active flag, hs and vs.
- S1: RAM read returns data. Flags are delayed one stage.
- S2: output registers.
- When active is 0, the RGB outputs are forced to 0.

Colour expansion:
- r8 = {r5, r5[4:2]}.
- g8 = {g6, g6[5:4]}.
- b8 = {b5, b5[4:2]}.

Read and write to the same address in the same cycle:
- The read returns the old data (read-before-write).
- The write still commits.

## Timing
- Reset values: counters 0, row base 0, red/green/blue_o 0, de_o 0, hsync_o 1, vsync_o 1, frame_start_o 0. Pipeline flags clear to the inactive state.
- Scanout latency: the output for counter state (h,v) appears 2 pix_ce_i ticks after the counters hold (h,v). hsync_o, vsync_o and de_o go through the same delay, so sync, de and colour are always aligned.
- Write-to-visible: a pixel written in cycle N is visible to any read issued in cycle N+1 or later.
- pix_ce_i low: all scanout registers hold, including the outputs. Writes still proceed.
- frame_start_o: fires in the clk_i cycle of the pix_ce_i that moves the counters from (799,524) to (0,0). It is not delayed by the pipeline, and it is low in every other cycle.
- Reset asserted mid-frame: all outputs take their reset values immediately (asynchronous). After release, scanout restarts at (0,0). RAM contents are not cleared.

## Test plan
- Reset then free-run with pix_ce_i=1 every cycle:
  - hsync_o low for exactly 96 ticks starting 2 ticks after h=656.
  - Line length 800 ticks.
  - vsync_o low for 2 lines.
  - de_o high for 640x480.
  - frame_start_o period 420000 ticks.
- Write 0xF800 to wr_addr_i=5120, and 0x001F to 5120+1*320+2=5442 (fb row 1, col 2):
  - output (0,0),(1,0),(0,1),(1,1) = R 0xFF, G 0, B 0.
  - output (4,2),(5,3) = B 0xFF.
- Write 0xFFFF to addresses 5119 and 81920 -> no framebuffer location changes; a full-frame readback matches the prior contents.
- Write and read the same address in one cycle -> the output shows the old value for that frame and the new value on the next frame.
- pix_ce_i toggled every 4th clock -> identical output sequence to the free-run case, sampled only on enabled ticks.
- Assert rst_ni mid-line at h=300, v=100 -> outputs go to reset values in the same cycle. After release the first frame_start_o occurs 420000 ticks later, and pixels written earlier remain visible.
